// File: rtl/bomberman_pkg.sv
// Shared types and constants for the player/map/renderer blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bomberman_pkg;

  typedef enum logic [1:0] {
    DIR_DOWN  = 2'd0,
    DIR_UP    = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  localparam int TILE_SHIFT  = 5;
  localparam int SPRITE_SIZE = 32;
  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;
  localparam int TILE_X_W    = 5;
  localparam int TILE_Y_W    = 5;
  localparam int POS_W       = 10;

  // Clamp an 11-bit signed candidate coordinate into [lo, hi]; negative
  // values land on lo instead of wrapping.
  function automatic logic [POS_W-1:0] clamp_axis(input logic signed [POS_W:0] v,
                                                  input int lo,
                                                  input int hi);
    if (v < $signed(11'(lo))) begin
      return 10'(lo);
    end else if (v > $signed(11'(hi))) begin
      return 10'(hi);
    end else begin
      return v[POS_W-1:0];
    end
  endfunction

endpackage

// File: rtl/player_anim.sv
// Walk-animation frame: counts committed moves, toggles frame every ANIM_DIV moves.
// Latency: frame updates on the edge that samples step/idle.
// Backpressure: none; idle clears counter and frame, idle wins over step.
module player_anim
  import bomberman_pkg::*;
#(
  parameter int ANIM_DIV = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic step,
  input  logic idle,
  output logic frame
);

  logic [7:0] cnt_q, cnt_d;
  logic       frame_q, frame_d;

  // Next-state: clear on idle, otherwise advance on each committed move.
  always_comb begin
    cnt_d   = cnt_q;
    frame_d = frame_q;
    if (idle) begin
      cnt_d   = '0;
      frame_d = 1'b0;
    end else if (step) begin
      if (cnt_q == 8'(ANIM_DIV - 1)) begin
        cnt_d   = '0;
        frame_d = ~frame_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  // Counter and frame registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
    end
  end

  assign frame = frame_q;

endmodule

// File: rtl/player_move.sv
// Per-player movement: samples buttons on frame_tick, checks two leading corners against the map, commits.
// Latency: tick cycle + >=1 per corner query + 1 commit; 3 cycles when corner A is a wall.
// Backpressure: map_req/tile held until map_ack; frame_tick while busy is dropped.
module player_move
  import bomberman_pkg::*;
#(
  parameter int START_X  = 32,
  parameter int START_Y  = 32,
  parameter int SPEED    = 2,
  parameter int X_MIN    = 32,
  parameter int X_MAX    = 576,
  parameter int Y_MIN    = 32,
  parameter int Y_MAX    = 416,
  parameter int ANIM_DIV = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_tick,
  input  logic                btn_up,
  input  logic                btn_down,
  input  logic                btn_left,
  input  logic                btn_right,
  output logic                map_req,
  output logic [TILE_X_W-1:0] map_tileX,
  output logic [TILE_Y_W-1:0] map_tileY,
  input  logic                map_ack,
  input  logic                map_wall,
  output logic [POS_W-1:0]    playerX,
  output logic [POS_W-1:0]    playerY,
  output logic [2:0]          sprite_num,
  output logic                busy
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CHECK_A = 2'd1;
  localparam logic [1:0] ST_CHECK_B = 2'd2;
  localparam logic [1:0] ST_COMMIT  = 2'd3;

  localparam logic signed [POS_W:0] SPD = 11'(SPEED);
  localparam logic [POS_W-1:0]      FAR = 10'(SPRITE_SIZE - 1);

  logic [1:0]       state_q, state_d;
  dir_t             dir_q, dir_d, btn_dir;
  logic [POS_W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [POS_W-1:0] cand_x_q, cand_x_d, cand_y_q, cand_y_d;
  logic             reject_q, reject_d;
  logic             any_btn;
  logic signed [POS_W:0] step_x, step_y;
  logic [POS_W-1:0] off_x, off_y;
  logic             anim_step, anim_idle, frame;

  assign any_btn = btn_up | btn_down | btn_left | btn_right;

  // Button priority: up > down > left > right.
  always_comb begin
    btn_dir = DIR_RIGHT;
    if (btn_up) begin
      btn_dir = DIR_UP;
    end else if (btn_down) begin
      btn_dir = DIR_DOWN;
    end else if (btn_left) begin
      btn_dir = DIR_LEFT;
    end
  end

  // Candidate position in 11-bit signed so a step below zero cannot wrap.
  always_comb begin
    step_x = $signed({1'b0, pos_x_q});
    step_y = $signed({1'b0, pos_y_q});
    case (btn_dir)
      DIR_UP:   step_y = step_y - SPD;
      DIR_DOWN: step_y = step_y + SPD;
      DIR_LEFT: step_x = step_x - SPD;
      default:  step_x = step_x + SPD;
    endcase
  end

  // FSM next-state, candidate latch and commit.
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    cand_x_d  = cand_x_q;
    cand_y_d  = cand_y_q;
    reject_d  = reject_q;
    anim_step = 1'b0;
    anim_idle = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frame_tick) begin
          if (any_btn) begin
            dir_d    = btn_dir;
            cand_x_d = clamp_axis(step_x, X_MIN, X_MAX);
            cand_y_d = clamp_axis(step_y, Y_MIN, Y_MAX);
            reject_d = 1'b0;
            state_d  = ST_CHECK_A;
          end else begin
            anim_idle = 1'b1;
          end
        end
      end
      ST_CHECK_A: begin
        if (map_ack) begin
          if (map_wall) begin
            reject_d = 1'b1;
            state_d  = ST_COMMIT;
          end else begin
            state_d = ST_CHECK_B;
          end
        end
      end
      ST_CHECK_B: begin
        if (map_ack) begin
          if (map_wall) begin
            reject_d = 1'b1;
          end
          state_d = ST_COMMIT;
        end
      end
      default: begin
        // A clamped no-op move neither moves nor advances the walk cycle.
        if (!reject_q && ((cand_x_q != pos_x_q) || (cand_y_q != pos_y_q))) begin
          pos_x_d   = cand_x_q;
          pos_y_d   = cand_y_q;
          anim_step = 1'b1;
        end
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, pose and candidate registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      dir_q    <= DIR_DOWN;
      pos_x_q  <= 10'(START_X);
      pos_y_q  <= 10'(START_Y);
      cand_x_q <= '0;
      cand_y_q <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      cand_x_q <= cand_x_d;
      cand_y_q <= cand_y_d;
      reject_q <= reject_d;
    end
  end

  // Leading-edge corner offsets for the corner currently being queried.
  always_comb begin
    off_x = '0;
    off_y = '0;
    case (dir_q)
      DIR_UP: begin
        if (state_q == ST_CHECK_B) off_x = FAR;
      end
      DIR_DOWN: begin
        off_y = FAR;
        if (state_q == ST_CHECK_B) off_x = FAR;
      end
      DIR_LEFT: begin
        if (state_q == ST_CHECK_B) off_y = FAR;
      end
      default: begin
        off_x = FAR;
        if (state_q == ST_CHECK_B) off_y = FAR;
      end
    endcase
  end

  assign map_req    = (state_q == ST_CHECK_A) || (state_q == ST_CHECK_B);
  assign map_tileX  = TILE_X_W'((cand_x_q + off_x) >> TILE_SHIFT);
  assign map_tileY  = TILE_Y_W'((cand_y_q + off_y) >> TILE_SHIFT);
  assign busy       = (state_q != ST_IDLE);
  assign playerX    = pos_x_q;
  assign playerY    = pos_y_q;
  assign sprite_num = {dir_q, frame};

  player_anim #(
    .ANIM_DIV(ANIM_DIV)
  ) u_anim (
    .clk  (clk),
    .reset(reset),
    .step (anim_step),
    .idle (anim_idle),
    .frame(frame)
  );

endmodule

// File: tb/tb_player_move.sv
module tb_player_move;

  localparam int START_X  = 32;
  localparam int START_Y  = 32;
  localparam int SPEED    = 2;
  localparam int X_MIN    = 32;
  localparam int X_MAX    = 576;
  localparam int Y_MIN    = 32;
  localparam int Y_MAX    = 416;
  localparam int ANIM_DIV = 8;

  logic       clk = 1'b0;
  logic       reset, frame_tick;
  logic       btn_up, btn_down, btn_left, btn_right;
  logic       map_req, map_ack, map_wall, busy;
  logic [4:0] map_tileX, map_tileY;
  logic [9:0] playerX, playerY;
  logic [2:0] sprite_num;

  always #5 clk = ~clk;

  player_move #(
    .START_X(START_X), .START_Y(START_Y), .SPEED(SPEED),
    .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX),
    .ANIM_DIV(ANIM_DIV)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .map_req(map_req), .map_tileX(map_tileX), .map_tileY(map_tileY),
    .map_ack(map_ack), .map_wall(map_wall),
    .playerX(playerX), .playerY(playerY), .sprite_num(sprite_num), .busy(busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Map model and responder state
  bit   walls [0:31][0:31];
  int   ack_delay = 0;
  bit   spurious  = 0;
  int   req_seen  = 0;
  bit   unstable  = 0;
  bit   in_req    = 0;
  int   wait_cnt  = 0;
  logic [4:0] hx, hy;
  int   q_tx[$];
  int   q_ty[$];

  // Reference model state
  int m_x, m_y, m_dir, m_frame, m_cnt;
  int e_n;
  int e_tx[2];
  int e_ty[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Map responder: answers each request after ack_delay wait cycles.
  initial begin
    map_ack  = 1'b0;
    map_wall = 1'b0;
    forever begin
      @(negedge clk);
      if (map_req === 1'b1) begin
        req_seen++;
        if (!in_req) begin
          in_req   = 1'b1;
          wait_cnt = 0;
          hx       = map_tileX;
          hy       = map_tileY;
        end else if (map_tileX !== hx || map_tileY !== hy) begin
          unstable = 1'b1;
        end
        if (wait_cnt >= ack_delay) begin
          map_ack  = 1'b1;
          map_wall = walls[map_tileX][map_tileY];
          q_tx.push_back(int'(map_tileX));
          q_ty.push_back(int'(map_tileY));
          in_req   = 1'b0;
        end else begin
          map_ack  = 1'b0;
          map_wall = 1'($urandom_range(0, 1));
          wait_cnt++;
        end
      end else begin
        in_req   = 1'b0;
        map_ack  = spurious;
        map_wall = spurious;
      end
    end
  end

  task automatic model_reset();
    m_x = START_X; m_y = START_Y; m_dir = 0; m_frame = 0; m_cnt = 0;
  endtask

  // Expected effect of one frame tick with the given buttons.
  task automatic model_tick(input bit u, input bit d, input bit l, input bit r);
    int dx, dy, cx, cy, ax, ay, bx, by;
    bit wa, wb;
    e_n = 0;
    if (!(u | d | l | r)) begin
      m_frame = 0;
      m_cnt   = 0;
      return;
    end
    dx = 0; dy = 0;
    if (u)      begin m_dir = 1; dy = -SPEED; end
    else if (d) begin m_dir = 0; dy =  SPEED; end
    else if (l) begin m_dir = 2; dx = -SPEED; end
    else        begin m_dir = 3; dx =  SPEED; end
    cx = clampi(m_x + dx, X_MIN, X_MAX);
    cy = clampi(m_y + dy, Y_MIN, Y_MAX);
    // Leading edge: top for up, bottom for down, left side, right side.
    case (m_dir)
      1:       begin ax = cx;      ay = cy;      bx = cx + 31; by = cy;      end
      0:       begin ax = cx;      ay = cy + 31; bx = cx + 31; by = cy + 31; end
      2:       begin ax = cx;      ay = cy;      bx = cx;      by = cy + 31; end
      default: begin ax = cx + 31; ay = cy;      bx = cx + 31; by = cy + 31; end
    endcase
    e_tx[0] = ax / 32; e_ty[0] = ay / 32; e_n = 1;
    wa = walls[e_tx[0]][e_ty[0]];
    wb = 1'b0;
    if (!wa) begin
      e_tx[1] = bx / 32; e_ty[1] = by / 32; e_n = 2;
      wb = walls[e_tx[1]][e_ty[1]];
    end
    if (!wa && !wb && (cx != m_x || cy != m_y)) begin
      m_x = cx;
      m_y = cy;
      m_cnt++;
      if (m_cnt == ANIM_DIV) begin
        m_cnt   = 0;
        m_frame = m_frame ^ 1;
      end
    end
  endtask

  // One frame: pulse tick, wait for completion, compare against the model.
  task automatic do_move(input bit u, input bit d, input bit l, input bit r,
                         input int delay, input bit extra, input int exp_lat);
    int lat;
    q_tx.delete();
    q_ty.delete();
    unstable  = 1'b0;
    ack_delay = delay;
    model_tick(u, d, l, r);
    btn_up = u; btn_down = d; btn_left = l; btn_right = r;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    lat = 1;
    while (busy && lat < 200) begin
      frame_tick = (extra && lat == 2);
      @(posedge clk); #1;
      frame_tick = 1'b0;
      lat++;
    end
    check("move_done", 32'(busy), 32'd0);
    if (exp_lat > 0) check("latency", lat, exp_lat);
    check("playerX", 32'(playerX), m_x);
    check("playerY", 32'(playerY), m_y);
    check("sprite_num", 32'(sprite_num), m_dir * 2 + m_frame);
    check("query_count", q_tx.size(), e_n);
    for (int i = 0; i < e_n && i < q_tx.size(); i++) begin
      check("query_tileX", q_tx[i], e_tx[i]);
      check("query_tileY", q_ty[i], e_ty[i]);
    end
    check("hs_stable", 32'(unstable), 32'd0);
  endtask

  initial begin
    int n;
    reset = 1'b1; frame_tick = 1'b0;
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_playerX", 32'(playerX), START_X);
    check("rst_playerY", 32'(playerY), START_Y);
    check("rst_sprite", 32'(sprite_num), 32'd0);
    check("rst_map_req", 32'(map_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    model_reset();

    // Idle frames: nothing moves, no map traffic.
    req_seen = 0;
    repeat (3) do_move(0, 0, 0, 0, 0, 0, 1);
    check("idle_no_req", req_seen, 32'd0);

    // Right step on an empty map, zero-wait.
    do_move(0, 0, 0, 1, 0, 0, 4);
    check("right_x34", 32'(playerX), 32'd34);
    check("right_sprite6", 32'(sprite_num), 32'd6);

    // Down to Y=34, then up into a wall at corner A.
    do_move(0, 1, 0, 0, 0, 0, 4);
    walls[1][1] = 1'b1;
    do_move(1, 0, 0, 0, 0, 0, 3);
    check("wall_y_held", 32'(playerY), 32'd34);
    check("wall_sprite2", 32'(sprite_num), 32'd2);
    walls[1][1] = 1'b0;

    // Slow map with an extra tick while busy: one move only.
    do_move(0, 0, 0, 1, 5, 1, 0);
    check("slow_one_move", 32'(playerX), 32'd36);

    // Spurious ack while idle is ignored.
    spurious = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    spurious = 1'b0;
    check("spurious_busy", 32'(busy), 32'd0);
    check("spurious_x", 32'(playerX), 32'd36);
    @(posedge clk); #1;

    // Walk animation: 8 moves toggle frame, releasing clears it.
    do_move(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 7; i++) do_move(0, 0, 0, 1, 0, 0, 4);
    check("anim_before_8", 32'(sprite_num), 32'd6);
    do_move(0, 0, 0, 1, 0, 0, 4);
    check("anim_after_8", 32'(sprite_num), 32'd7);
    do_move(0, 0, 0, 0, 0, 0, 1);
    check("anim_release", 32'(sprite_num), 32'd6);

    // Up to Y_MIN, then clamp at the top edge.
    do_move(1, 0, 0, 0, 0, 0, 4);
    do_move(1, 0, 0, 0, 0, 0, 4);
    check("clamp_y_min", 32'(playerY), Y_MIN);

    // Walk right to X_MAX, then one more clamped move.
    n = 0;
    while (m_x < X_MAX && n < 400) begin
      do_move(0, 0, 0, 1, 0, 0, 4);
      n++;
    end
    do_move(0, 0, 0, 1, 0, 0, 4);
    check("clamp_x_max", 32'(playerX), X_MAX);

    // Reset while waiting in the second corner query.
    q_tx.delete(); q_ty.delete();
    ack_delay = 3;
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b1; btn_right = 1'b0;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    n = 0;
    while (!(q_tx.size() == 1 && map_req === 1'b1) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_check_b", 32'(n < 50), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    check("midrst_map_req", 32'(map_req), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_x", 32'(playerX), START_X);
    check("midrst_y", 32'(playerY), START_Y);
    check("midrst_sprite", 32'(sprite_num), 32'd0);
    @(posedge clk); #1;

    // Randomized frames on random maps and random map latency.
    for (int it = 0; it < 120; it++) begin
      if (it % 20 == 0) begin
        for (int i = 0; i < 32; i++)
          for (int j = 0; j < 32; j++)
            walls[i][j] = ($urandom_range(0, 99) < 12);
      end
      n = $urandom_range(0, 15);
      do_move(n[0], n[1], n[2], n[3], $urandom_range(0, 3),
              ($urandom_range(0, 3) == 0), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
